memory_access_controller: RTL and testbench
===========================================

MEMORY_ACCESS_CONTROLLER -- requirements
Module: memory_access_controller

Interface
REQ-001 Parameter WORD, 16, data/address width in bits.
REQ-002 Parameter TIMEOUT, 15, maximum bus cycles waited for mem_ack_i before fault.
REQ-003 The design SHALL use one clock; reset is synchronous and active-high.
REQ-004 Ports SHALL be as follows:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous active-high reset.
- req_i  in  1  access request from CPU control.
- cmd_i  in  3  {RW, HB, LB} access command; RW=1 means write.
- addr_i  in  WORD  byte address.
- bad_addr_i  in  1  misaligned-address flag.
- wdata_i  in  WORD  write data.
- busy_o  out  1  access in progress.
- done_o  out  1  one-cycle completion pulse.
- fault_o  out  1  one-cycle fault pulse.
- fault_code_o  out  2  0 none, 1 misaligned, 2 reserved cmd, 3 timeout.
- rdata_o  out  WORD  read result.
- mem_req_o  out  1  bus request.
- mem_we_o  out  1  bus write enable.
- mem_be_o  out  2  byte enables {HB, LB}.
- mem_addr_o  out  WORD  word address (bit 0 forced 0).
- mem_wdata_o  out  WORD  bus write data.
- mem_rdata_i  in  WORD  bus read data.
- mem_ack_i  in  1  bus acknowledge.

Function
REQ-005 FSM states SHALL be IDLE, CHECK, BUS, DONE and FAULT.
REQ-006 In IDLE with req_i=1, cmd_i, addr_i, wdata_i and bad_addr_i SHALL be registered; the FSM goes to CHECK; busy_o=1 from the next cycle.
REQ-007 In IDLE, req_i SHALL be ignored when busy_o=1; inputs are sampled only on acceptance.
REQ-008 CHECK SHALL go to FAULT when a fault applies, with priority misaligned (1) over reserved cmd (2).
- Misaligned: latched bad_addr_i=1.
- Reserved cmd: HB=LB=0.
- Otherwise CHECK SHALL go to BUS.
REQ-009 In BUS, mem_req_o=1 and mem_addr_o={addr[WORD-1:1],0} SHALL hold stable until mem_ack_i=1.
REQ-010 In BUS, mem_we_o=RW and mem_be_o={HB,LB} SHALL hold stable until mem_ack_i=1.
REQ-011 Byte write mem_wdata_o SHALL be {wdata[7:0],wdata[7:0]}; word write SHALL be wdata unchanged.
REQ-012 On a read ack, rdata_o SHALL be registered:
- Word read (HB=LB=1): mem_rdata_i.
- LB-only read: zero-extended mem_rdata_i[7:0].
- HB-only read: zero-extended mem_rdata_i[15:8].
REQ-013 rdata_o SHALL hold its value until the next read ack; writes SHALL leave rdata_o unchanged.
REQ-014 A timeout counter SHALL clear on entry to BUS and increment each BUS cycle without ack.
REQ-015 If the count reaches TIMEOUT with no ack, the FSM SHALL go to FAULT with code 3 and drop mem_req_o.
REQ-016 An ack arriving in the same cycle the count reaches TIMEOUT SHALL win; the access completes normally.
REQ-017 DONE SHALL assert done_o for one cycle, then return to IDLE.
REQ-018 FAULT SHALL assert fault_o for one cycle with fault_code_o valid, then return to IDLE.
REQ-019 fault_code_o SHALL hold until the next accepted request, where it clears to 0.
REQ-020 busy_o SHALL be 1 in CHECK, BUS, DONE and FAULT, and 0 in IDLE.
REQ-021 Back-to-back operation: req_i seen in the cycle after DONE/FAULT (IDLE) SHALL be accepted, giving a minimum 4-cycle access with ack in the first BUS cycle.
REQ-022 mem_ack_i outside BUS SHALL be ignored.

Reset
REQ-023 rst_i=1 SHALL force IDLE from any state, including mid-BUS; an access interrupted mid-BUS by reset produces no done_o and no fault_o.
REQ-024 All outputs SHALL reset to 0, and the timeout counter SHALL reset to 0.

Structure
REQ-025 A shared package SHALL hold:
- The state enum.
- The fault code enum.
- The LB/HB/RW command bit indices.
- The WORD default.
REQ-026 One sub-module, mem_lane_align, SHALL implement the combinational write replication and read lane select/zero-extension.

Verification
REQ-027 Word read, addr 0x0100, cmd 011, ack in 1st BUS cycle -> mem_be_o=11, rdata_o=mem_rdata_i (0xBEEF), done_o 3 cycles after acceptance.
REQ-028 Byte write, addr 0x0101, cmd 110, wdata 0x00A5 -> mem_addr_o=0x0100, be=10, mem_wdata_o=0xA5A5, we=1.
REQ-029 HB byte read with mem_rdata_i=0x12AB -> rdata_o=0x0012.
REQ-030 Fault cases:
- bad_addr_i=1 with cmd 000 -> fault_code 1, no mem_req_o.
- cmd 100 alone -> fault_code 2, no mem_req_o.
REQ-031 No ack for 15 BUS cycles -> fault_code 3; a repeat with ack on the 15th cycle -> done_o, no fault.
REQ-032 rst_i pulsed mid-BUS -> next cycle IDLE, all outputs 0, no done_o or fault_o.

Source files
------------

// File: rtl/memory_access_controller_pkg.sv
// Shared types and constants for the memory access controller.
package memory_access_controller_pkg;

    localparam int WORD_DEFAULT = 16;

    // Command bit positions within cmd_i = {RW, HB, LB}
    localparam int CMD_LB = 0;
    localparam int CMD_HB = 1;
    localparam int CMD_RW = 2;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CHECK = 3'd1,
        ST_BUS   = 3'd2,
        ST_DONE  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        FC_NONE       = 2'd0,
        FC_MISALIGNED = 2'd1,
        FC_RESERVED   = 2'd2,
        FC_TIMEOUT    = 2'd3
    } fault_t;

endpackage

// File: rtl/memory_access_controller_mem_lane_align.sv
// Byte-lane steering: replicate the low byte on byte writes and select /
// zero-extend the addressed lane on byte reads.
module mem_lane_align #(
    parameter int WORD = 16
) (
    input  logic            hb,
    input  logic            lb,
    input  logic [WORD-1:0] wdata,
    input  logic [WORD-1:0] mem_rdata,
    output logic [WORD-1:0] bus_wdata,
    output logic [WORD-1:0] rd_data
);

    // Lane steering is purely combinational; exactly one enable set means a byte access
    always_comb begin
        bus_wdata = wdata;
        rd_data   = mem_rdata;
        if (hb ^ lb) begin
            bus_wdata = {(WORD/8){wdata[7:0]}};
            if (hb) begin
                rd_data = {{(WORD-8){1'b0}}, mem_rdata[15:8]};
            end else begin
                rd_data = {{(WORD-8){1'b0}}, mem_rdata[7:0]};
            end
        end
    end

endmodule

// File: rtl/memory_access_controller.sv
// Single-access memory controller: latches a CPU request, validates it,
// runs one bus transaction with a bounded ack wait, and reports done/fault.
//
// state | meaning
// IDLE  | waiting for req_i; inputs latched on acceptance
// CHECK | evaluate misaligned / reserved-command faults
// BUS   | bus request held until ack or timeout
// DONE  | one-cycle completion pulse
// FAULT | one-cycle fault pulse, fault_code_o valid
module memory_access_controller
    import memory_access_controller_pkg::*;
#(
    parameter int WORD    = WORD_DEFAULT,
    parameter int TIMEOUT = 15
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            req_i,
    input  logic [2:0]      cmd_i,
    input  logic [WORD-1:0] addr_i,
    input  logic            bad_addr_i,
    input  logic [WORD-1:0] wdata_i,
    output logic            busy_o,
    output logic            done_o,
    output logic            fault_o,
    output logic [1:0]      fault_code_o,
    output logic [WORD-1:0] rdata_o,
    output logic            mem_req_o,
    output logic            mem_we_o,
    output logic [1:0]      mem_be_o,
    output logic [WORD-1:0] mem_addr_o,
    output logic [WORD-1:0] mem_wdata_o,
    input  logic [WORD-1:0] mem_rdata_i,
    input  logic            mem_ack_i
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t          state, state_next;
    fault_t          fault_next, fault_code_q;
    logic [2:0]      cmd_q;
    logic [WORD-1:0] addr_q;
    logic [WORD-1:0] wdata_q;
    logic            bad_q;
    logic [CNT_W-1:0] cnt;
    logic [WORD-1:0] rdata_q;
    logic [WORD-1:0] bus_wdata;
    logic [WORD-1:0] rd_aligned;
    logic            in_bus;
    logic            accept;

    assign in_bus = (state == ST_BUS);
    assign accept = (state == ST_IDLE) && req_i;

    mem_lane_align #(.WORD(WORD)) u_lane (
        .hb        (cmd_q[CMD_HB]),
        .lb        (cmd_q[CMD_LB]),
        .wdata     (wdata_q),
        .mem_rdata (mem_rdata_i),
        .bus_wdata (bus_wdata),
        .rd_data   (rd_aligned)
    );

    // Next-state and fault classification
    always_comb begin
        state_next = state;
        fault_next = FC_NONE;
        case (state)
            ST_IDLE: begin
                if (req_i) state_next = ST_CHECK;
            end
            ST_CHECK: begin
                if (bad_q) begin
                    state_next = ST_FAULT;
                    fault_next = FC_MISALIGNED;
                end else if (!cmd_q[CMD_HB] && !cmd_q[CMD_LB]) begin
                    state_next = ST_FAULT;
                    fault_next = FC_RESERVED;
                end else begin
                    state_next = ST_BUS;
                end
            end
            ST_BUS: begin
                // Ack takes priority over a timeout landing in the same cycle
                if (mem_ack_i) begin
                    state_next = ST_DONE;
                end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                    state_next = ST_FAULT;
                    fault_next = FC_TIMEOUT;
                end
            end
            ST_DONE:  state_next = ST_IDLE;
            ST_FAULT: state_next = ST_IDLE;
            default:  state_next = ST_IDLE;
        endcase
    end

    // State, request latches, timeout counter, fault code and read data
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state        <= ST_IDLE;
            cmd_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            bad_q        <= 1'b0;
            cnt          <= '0;
            fault_code_q <= FC_NONE;
            rdata_q      <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                cmd_q        <= cmd_i;
                addr_q       <= addr_i;
                wdata_q      <= wdata_i;
                bad_q        <= bad_addr_i;
                fault_code_q <= FC_NONE;
            end
            if (state_next == ST_FAULT) begin
                fault_code_q <= fault_next;
            end
            if (!in_bus) begin
                cnt <= '0;
            end else if (!mem_ack_i) begin
                cnt <= cnt + CNT_W'(1);
            end
            if (in_bus && mem_ack_i && !cmd_q[CMD_RW]) begin
                rdata_q <= rd_aligned;
            end
        end
    end

    assign busy_o       = (state != ST_IDLE);
    assign done_o       = (state == ST_DONE);
    assign fault_o      = (state == ST_FAULT);
    assign fault_code_o = fault_code_q;
    assign rdata_o      = rdata_q;
    assign mem_req_o    = in_bus;
    assign mem_we_o     = in_bus & cmd_q[CMD_RW];
    assign mem_be_o     = in_bus ? {cmd_q[CMD_HB], cmd_q[CMD_LB]} : 2'b00;
    assign mem_addr_o   = in_bus ? (addr_q & ~WORD'(1)) : '0;
    assign mem_wdata_o  = in_bus ? bus_wdata : '0;

endmodule

// File: tb/tb_memory_access_controller.sv
// Directed bench for memory_access_controller with hand-computed expectations.
module tb_memory_access_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [2:0]  cmd;
    logic [15:0] addr;
    logic        bad_addr;
    logic [15:0] wdata;
    logic        busy, done, fault;
    logic [1:0]  fault_code;
    logic [15:0] rdata;
    logic        mem_req, mem_we;
    logic [1:0]  mem_be;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_ack;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    memory_access_controller #(.WORD(16), .TIMEOUT(15)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_i        (req),
        .cmd_i        (cmd),
        .addr_i       (addr),
        .bad_addr_i   (bad_addr),
        .wdata_i      (wdata),
        .busy_o       (busy),
        .done_o       (done),
        .fault_o      (fault),
        .fault_code_o (fault_code),
        .rdata_o      (rdata),
        .mem_req_o    (mem_req),
        .mem_we_o     (mem_we),
        .mem_be_o     (mem_be),
        .mem_addr_o   (mem_addr),
        .mem_wdata_o  (mem_wdata),
        .mem_rdata_i  (mem_rdata),
        .mem_ack_i    (mem_ack)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Drive one request for a single cycle; returns at the CHECK-state negedge
    task automatic issue(input logic [2:0] c, input logic [15:0] a,
                         input logic b, input logic [15:0] w);
        req = 1'b1; cmd = c; addr = a; bad_addr = b; wdata = w;
        step();
        req = 1'b0; cmd = 3'b000; addr = 16'hFFFF; bad_addr = 1'b0; wdata = 16'hFFFF;
    endtask

    initial begin
        rst = 1'b1; req = 1'b0; cmd = '0; addr = '0; bad_addr = 1'b0;
        wdata = '0; mem_rdata = '0; mem_ack = 1'b0;
        step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_outs", {done, fault, fault_code, mem_req, mem_we, mem_be}, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_maddr", mem_addr, 0);
        rst = 1'b0;
        step();

        // Word read, ack in first BUS cycle
        issue(3'b011, 16'h0100, 1'b0, 16'h0000);
        chk("rd_check_busy", busy, 1);
        chk("rd_check_noreq", mem_req, 0);
        step();
        chk("rd_bus_req", mem_req, 1);
        chk("rd_bus_addr", mem_addr, 16'h0100);
        chk("rd_bus_be", mem_be, 2'b11);
        chk("rd_bus_we", mem_we, 0);
        mem_ack = 1'b1; mem_rdata = 16'hBEEF;
        step();
        mem_ack = 1'b0; mem_rdata = 16'h0000;
        chk("rd_done", done, 1);
        chk("rd_rdata", rdata, 16'hBEEF);
        chk("rd_done_noreq", mem_req, 0);
        step();
        chk("rd_idle", {busy, done}, 2'b00);

        // Byte write on odd address
        issue(3'b110, 16'h0101, 1'b0, 16'h00A5);
        step();
        chk("wr_addr", mem_addr, 16'h0100);
        chk("wr_be", mem_be, 2'b10);
        chk("wr_wdata", mem_wdata, 16'hA5A5);
        chk("wr_we", mem_we, 1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        chk("wr_done", done, 1);
        chk("wr_rdata_kept", rdata, 16'hBEEF);
        step();

        // HB byte read
        issue(3'b010, 16'h0200, 1'b0, 16'h0000);
        step();
        chk("hb_be", mem_be, 2'b10);
        mem_ack = 1'b1; mem_rdata = 16'h12AB;
        step();
        mem_ack = 1'b0;
        chk("hb_rdata", rdata, 16'h0012);
        step();

        // LB byte read
        issue(3'b001, 16'h0202, 1'b0, 16'h0000);
        step();
        chk("lb_be", mem_be, 2'b01);
        mem_ack = 1'b1; mem_rdata = 16'h12AB;
        step();
        mem_ack = 1'b0;
        chk("lb_rdata", rdata, 16'h00AB);
        step();

        // Misaligned beats reserved command
        issue(3'b000, 16'h0003, 1'b1, 16'h0000);
        chk("mis_check_noreq", mem_req, 0);
        step();
        chk("mis_fault", {fault, done, mem_req}, 3'b100);
        chk("mis_code", fault_code, 1);
        step();
        chk("mis_code_hold", {busy, fault, fault_code}, 4'b0001);

        // Reserved command: code clears on acceptance
        issue(3'b100, 16'h0010, 1'b0, 16'h0000);
        chk("res_code_clr", fault_code, 0);
        step();
        chk("res_fault", {fault, mem_req}, 2'b10);
        chk("res_code", fault_code, 2);
        step();

        // Ack outside BUS is ignored
        mem_ack = 1'b1;
        step();
        chk("idle_ack", {busy, done, fault}, 3'b000);
        mem_ack = 1'b0;

        // Timeout: no ack for 15 BUS cycles
        issue(3'b011, 16'h0400, 1'b0, 16'h0000);
        step();
        for (int i = 1; i <= 15; i++) begin
            chk($sformatf("to_req_%0d", i), {mem_req, fault}, 2'b10);
            step();
        end
        chk("to_fault", {fault, mem_req, done}, 3'b100);
        chk("to_code", fault_code, 3);
        step();

        // Ack on the 15th BUS cycle wins over timeout; back-to-back request
        issue(3'b011, 16'h0400, 1'b0, 16'h0000);
        step();
        for (int i = 1; i <= 14; i++) step();
        chk("to15_req", mem_req, 1);
        mem_ack = 1'b1; mem_rdata = 16'h5A5A;
        step();
        mem_ack = 1'b0;
        chk("to15_done", {done, fault}, 2'b10);
        chk("to15_rdata", rdata, 16'h5A5A);
        req = 1'b1; cmd = 3'b011; addr = 16'h0600;
        step();
        chk("b2b_idle", busy, 0);
        step();
        req = 1'b0;
        chk("b2b_accept", busy, 1);
        step();
        chk("b2b_bus_addr", mem_addr, 16'h0600);

        // Reset mid-BUS
        step();
        chk("rst_mid_req", mem_req, 1);
        rst = 1'b1;
        step();
        chk("rst_mid_outs", {busy, done, fault, fault_code, mem_req, mem_we, mem_be}, 0);
        chk("rst_mid_data", {rdata, mem_addr, mem_wdata}, 0);
        rst = 1'b0;
        step();
        chk("rst_mid_after", {busy, done, fault}, 3'b000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1);
    end

endmodule
